// File: rtl/latch8_share_ctrl.sv
// Purpose : round-robin arbiter/sequencer sharing one 8-bit latch register bank among four requesters.
// Latency : grant, D_out and ld appear one cycle after req is sampled in IDLE; commands strobe one cycle after sampling.
// Backpressure: requesters hold req (and callers hold commands) until done / busy=0; nothing is queued.
//
// Optional feature macro: LATCH8_SHARE_HOLD_EN
//   defined   -> HOLD state keeps ownership for HOLD_CYCLES after the load (gnt high 1+HOLD_CYCLES cycles)
//   undefined -> LOAD returns straight to IDLE (gnt high one cycle, HOLD_CYCLES ignored)
//
// Ports:
//   CLK, Clrn          clock (rising edge), asynchronous active-low reset
//   req[3:0]           level requests, held until done
//   din0..din3         byte offered by each requester
//   clr_cmd, set_cmd   requests to clear / set the register bank (accepted only in IDLE)
//   gnt[3:0]           one-hot grant
//   done[3:0]          one-cycle completion pulse to the requester that owned the bank
//   D_out[7:0], ld     byte and single-cycle load strobe to the register bank
//   Setn_out, Clrn_out active-low set / clear strobes to the register bank
//   busy               high whenever the sequencer is not in IDLE
//   owner[1:0]         index of the last granted requester
module latch8_share_ctrl #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       Clrn,
    input  logic [3:0] req,
    input  logic [7:0] din0,
    input  logic [7:0] din1,
    input  logic [7:0] din2,
    input  logic [7:0] din3,
    input  logic       clr_cmd,
    input  logic       set_cmd,
    output logic [3:0] gnt,
    output logic [3:0] done,
    output logic [7:0] D_out,
    output logic       ld,
    output logic       Setn_out,
    output logic       Clrn_out,
    output logic       busy,
    output logic [1:0] owner
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_hold_range
        $error("HOLD_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
`ifdef LATCH8_SHARE_HOLD_EN
        HOLD = 2'd2,
`endif
        CMD  = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] ptr;       // last winner; search starts at ptr+1
`ifdef LATCH8_SHARE_HOLD_EN
    logic [7:0] hold_cnt;
`endif

    logic [1:0] win;
    logic       win_vld;
    logic [1:0] cand;
    logic [7:0] win_din;

    // Walk from lowest to highest priority so the highest-priority hit
    // (ptr+1) is the last assignment and therefore wins.
    always_comb begin
        win     = ptr;
        win_vld = 1'b0;
        cand    = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_din = din0;
        case (win)
            2'd0: win_din = din0;
            2'd1: win_din = din1;
            2'd2: win_din = din2;
            2'd3: win_din = din3;
            default: win_din = din0;
        endcase
    end

    always_ff @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            state    <= IDLE;
            ptr      <= 2'd3;
            gnt      <= 4'd0;
            done     <= 4'd0;
            D_out    <= 8'h00;
            ld       <= 1'b0;
            Setn_out <= 1'b1;
            Clrn_out <= 1'b1;
            busy     <= 1'b0;
            owner    <= 2'd0;
`ifdef LATCH8_SHARE_HOLD_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            // Strobes are single-cycle by default; each state re-asserts as needed.
            ld       <= 1'b0;
            done     <= 4'd0;
            Setn_out <= 1'b1;
            Clrn_out <= 1'b1;
            case (state)
                IDLE: begin
                    if (clr_cmd) begin
                        // Clear beats set; a simultaneous set is dropped.
                        state    <= CMD;
                        Clrn_out <= 1'b0;
                        busy     <= 1'b1;
                    end else if (set_cmd) begin
                        state    <= CMD;
                        Setn_out <= 1'b0;
                        busy     <= 1'b1;
                    end else if (win_vld) begin
                        state <= LOAD;
                        gnt   <= 4'b0001 << win;
                        D_out <= win_din;
                        ld    <= 1'b1;
                        owner <= win;
                        ptr   <= win;
                        busy  <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
`ifdef LATCH8_SHARE_HOLD_EN
                    state    <= HOLD;
                    hold_cnt <= 8'(HOLD_CYCLES - 1);
`else
                    state <= IDLE;
                    gnt   <= 4'd0;
                    done  <= gnt;
                    busy  <= 1'b0;
`endif
                end
`ifdef LATCH8_SHARE_HOLD_EN
                HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        state <= IDLE;
                        gnt   <= 4'd0;
                        done  <= gnt;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
`endif
                CMD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch8_share_ctrl.sv
// Purpose : directed bench for latch8_share_ctrl with a grant scoreboard.
// Latency : expects grant one cycle after req, gnt width 1+HOLD (or 1), period width+1.
// Backpressure: requests are held by the bench until the grant is observed.
module tb_latch8_share_ctrl;

    localparam int H = 8;
`ifdef LATCH8_SHARE_HOLD_EN
    localparam int GW = 1 + H;
`else
    localparam int GW = 1;
`endif
    localparam int PER = GW + 1;

    logic       CLK = 1'b0;
    logic       Clrn;
    logic [3:0] req;
    logic [7:0] din0, din1, din2, din3;
    logic       clr_cmd, set_cmd;
    logic [3:0] gnt, done;
    logic [7:0] D_out;
    logic       ld, Setn_out, Clrn_out, busy;
    logic [1:0] owner;

    latch8_share_ctrl #(.HOLD_CYCLES(H)) dut (
        .CLK(CLK), .Clrn(Clrn), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .clr_cmd(clr_cmd), .set_cmd(set_cmd),
        .gnt(gnt), .done(done), .D_out(D_out), .ld(ld),
        .Setn_out(Setn_out), .Clrn_out(Clrn_out), .busy(busy), .owner(owner)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         idx;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] dsel(input int i);
        case (i)
            0: dsel = din0;
            1: dsel = din1;
            2: dsel = din2;
            default: dsel = din3;
        endcase
    endfunction

    task automatic push(input int i);
        exp_t e;
        e.idx = i;
        e.d   = dsel(i);
        sb.push_back(e);
    endtask

    // Steps until ld is seen (bounded), then pops the scoreboard and compares.
    task automatic wait_grant(input string tag, output int n, output exp_t e);
        logic [3:0] oh;
        n     = 0;
        e.idx = 0;
        e.d   = 8'h00;
        do begin
            tick();
            n++;
        end while (ld !== 1'b1 && n < 100);
        chk({tag, "_ld"}, 32'(ld), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            oh = 4'b0001 << e.idx;
            chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
            chk({tag, "_dout"}, 32'(D_out), 32'(e.d));
            chk({tag, "_owner"}, 32'(owner), 32'(e.idx));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
    endtask

    // Called on the cycle ld was seen; follows gnt to its fall and the done pulse.
    task automatic measure(input string tag, input exp_t e);
        int         w;
        int         extra_ld;
        int         bad;
        int         cmdlow;
        logic [3:0] oh;
        w        = 1;
        extra_ld = 0;
        bad      = 0;
        cmdlow   = 0;
        oh       = 4'b0001 << e.idx;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (gnt === 4'd0) break;
            w++;
            if (ld !== 1'b0) extra_ld++;
            if (gnt !== oh || D_out !== e.d) bad++;
            if (Setn_out !== 1'b1 || Clrn_out !== 1'b1) cmdlow++;
        end
        chk({tag, "_gnt_width"}, 32'(w), 32'(GW));
        chk({tag, "_ld_single"}, 32'(extra_ld), 32'd0);
        chk({tag, "_hold_stable"}, 32'(bad), 32'd0);
        chk({tag, "_no_cmd_in_txn"}, 32'(cmdlow), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'(oh));
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        Clrn = 1'b0;
        tick();
        Clrn = 1'b1;
    endtask

    initial begin : stim
        int   n;
        int   prev;
        exp_t e;

        Clrn    = 1'b0;
        req     = 4'd0;
        din0    = 8'h00;
        din1    = 8'h00;
        din2    = 8'h00;
        din3    = 8'h00;
        clr_cmd = 1'b0;
        set_cmd = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", 32'(D_out), 32'h00);
        chk("rst_ld", 32'(ld), 32'd0);
        chk("rst_setn", 32'(Setn_out), 32'd1);
        chk("rst_clrn", 32'(Clrn_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        Clrn = 1'b1;
        tick();

        // Single request from requester 0; req dropped and din changed mid-transaction
        din0 = 8'hA5;
        req  = 4'b0001;
        push(0);
        wait_grant("t1", n, e);
        chk("t1_latency", 32'(n), 32'd1);
        req  = 4'b0000;
        din0 = 8'h3C;
        measure("t1", e);
        tick();
        chk("t1_done_clear", 32'(done), 32'd0);
        chk("t1_no_regrant", 32'(ld), 32'd0);

        // All four requesting: round robin 0,1,2,3,0 from reset
        pulse_reset();
        din0 = 8'h11;
        din1 = 8'h22;
        din2 = 8'h33;
        din3 = 8'h44;
        req  = 4'b1111;
        push(0);
        push(1);
        push(2);
        push(3);
        push(0);
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant($sformatf("rr%0d", k), n, e);
            if (k > 0) chk($sformatf("rr%0d_period", k), 32'(cyc - prev), 32'(PER));
            prev = cyc;
            if (k == 4) req = 4'b0000;
            measure($sformatf("rr%0d", k), e);
        end
        tick();

        // Clear and set together: clear wins, set dropped
        clr_cmd = 1'b1;
        set_cmd = 1'b1;
        tick();
        chk("cmd_both_clrn", 32'(Clrn_out), 32'd0);
        chk("cmd_both_setn", 32'(Setn_out), 32'd1);
        chk("cmd_both_busy", 32'(busy), 32'd1);
        clr_cmd = 1'b0;
        set_cmd = 1'b0;
        tick();
        chk("cmd_both_clrn_rel", 32'(Clrn_out), 32'd1);
        chk("cmd_both_setn_rel", 32'(Setn_out), 32'd1);
        chk("cmd_both_busy_rel", 32'(busy), 32'd0);
        set_cmd = 1'b1;
        tick();
        chk("cmd_set_setn", 32'(Setn_out), 32'd0);
        chk("cmd_set_clrn", 32'(Clrn_out), 32'd1);
        set_cmd = 1'b0;
        tick();
        chk("cmd_set_setn_rel", 32'(Setn_out), 32'd1);

        // set_cmd raised mid-transaction and held; req 2 stays pending
        din2 = 8'h5E;
        req  = 4'b0100;
        push(2);
        wait_grant("t4a", n, e);
        set_cmd = 1'b1;
        measure("t4a", e);
        chk("t4_setn_done_cycle", 32'(Setn_out), 32'd1);
        tick();
        chk("t4_setn_low", 32'(Setn_out), 32'd0);
        chk("t4_no_grant", 32'(gnt), 32'd0);
        chk("t4_busy_cmd", 32'(busy), 32'd1);
        set_cmd = 1'b0;
        push(2);
        wait_grant("t4b", n, e);
        chk("t4b_latency", 32'(n), 32'd2);
        req = 4'b0000;
        measure("t4b", e);
        tick();

        // Reset in the middle of requester 2's ownership
        req = 4'b0100;
        push(2);
        wait_grant("t5a", n, e);
        req = 4'b0000;
        #2;
        Clrn = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(gnt), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ld", 32'(ld), 32'd0);
        chk("t5_rst_owner", 32'(owner), 32'd0);
        tick();
        chk("t5_rst_no_done", 32'(done), 32'd0);
        Clrn = 1'b1;
        din0 = 8'h99;
        req  = 4'b0101;
        push(0);
        wait_grant("t5b", n, e);
        req = 4'b0000;
        measure("t5b", e);
        tick();

        // Two requesters from reset: 0 then 1, one period apart
        pulse_reset();
        din0 = 8'h5A;
        din1 = 8'hC3;
        req  = 4'b0011;
        push(0);
        push(1);
        wait_grant("t6a", n, e);
        prev = cyc;
        measure("t6a", e);
        wait_grant("t6b", n, e);
        chk("t6_period", 32'(cyc - prev), 32'(PER));
        req = 4'b0000;
        measure("t6b", e);
        tick();
        chk("t6_idle", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/latch8_share_ctrl.md
# latch8_share_ctrl

Sequencer and arbiter that shares one 8-bit D-latch register bank, with per-bit async set/clear and LED mirror, among four requesters. It round-robin grants one requester at a time, presents that requester's byte on the register's D bus, and issues a single-cycle load strobe. It holds ownership for a programmable display time, and sequences the register's active-low set/clear lines on command. It sits between the switch and key front-end logic and the 8-bit register bank on the lab board.

## Interface
Parameters:
- HOLD_CYCLES, 8: cycles ownership is held after a load (1..255).

Ports:
- CLK  in  1  system clock, all state updates on its rising edge.
- Clrn  in  1  asynchronous active-low reset.
- req  in  4  request per requester; level, held until done.
- din0, din1, din2, din3  in  8 each  byte offered by requester n.
- clr_cmd  in  1  synchronous request to clear the register bank.
- set_cmd  in  1  synchronous request to set the register bank to 8'hFF.
- gnt  out  4  one-hot grant, registered.
- done  out  4  one-cycle completion pulse to the granted requester.
- D_out  out  8  byte to register D inputs.
- ld  out  1  one-cycle load strobe, the register clock enable.
- Setn_out  out  1  active-low set to the register bank.
- Clrn_out  out  1  active-low clear to the register bank.
- busy  out  1  high in any state other than IDLE.
- owner  out  2  index of the last granted requester.

## Operation
- States: IDLE, LOAD, HOLD, CMD. All outputs are registered.
- Reset values (Clrn low, async): state IDLE, gnt 0, done 0, D_out 8'h00, ld 0, Setn_out 1, Clrn_out 1, busy 0, owner 0, rr pointer 3, so req[0] has first priority.
- IDLE priority, evaluated each edge:
  - clr_cmd first.
  - then set_cmd.
  - then req.
- clr_cmd in IDLE: go to CMD, Clrn_out=0 for exactly one cycle, then return to IDLE.
- set_cmd in IDLE: same, but with Setn_out=0.
- clr_cmd and set_cmd together: clear wins and set is dropped, not queued. Setn_out and Clrn_out are never low together.
- Commands outside IDLE are ignored. Callers keep them high until busy=0.
- req in IDLE, no command:
  - Winner is the first asserted req searching from pointer+1 modulo 4.
  - go to LOAD with gnt=onehot(winner), D_out=din[winner], ld=1, owner=winner, pointer=winner.
- LOAD: ld=1 for this one cycle. Next edge goes to HOLD with ld=0; D_out and gnt stay unchanged.
- HOLD:
  - Counter is loaded with HOLD_CYCLES-1 on entry and decrements each cycle.
  - At 0, go to IDLE with gnt=0 and done=previous gnt (one cycle).
- din is sampled only on the IDLE→LOAD edge. Later din changes do not affect D_out.
- req dropped during LOAD or HOLD: the transaction still completes and done still pulses.
- Owner re-requesting immediately: it is granted again only if no other req is asserted.
- D_out keeps its last value in IDLE and CMD.

## Timing
- req sampled high at edge E: ld and gnt go high after E, and ld low after E+1.
- gnt stays high for 1+HOLD_CYCLES cycles.
- done pulses in the cycle after gnt falls, returning to IDLE.
- Next grant earliest edge is the one after done is seen in IDLE. Back-to-back period is 2+HOLD_CYCLES cycles.
- Command latency: edge E sample, then the strobe is low for one cycle after E, with busy=1 for that cycle.
- Reset mid-transaction: all outputs go to reset values immediately, with no done pulse. The register bank is not cleared by this block on reset.

## Configuration
- LATCH8_SHARE_HOLD_EN defined: HOLD state and counter present, as described above.
- Not defined: no HOLD state, and HOLD_CYCLES is ignored.
  - LOAD goes straight to IDLE with gnt=0 and done=previous gnt.
  - gnt is high for one cycle and the back-to-back period is 2 cycles.

## Test plan
- Reset, then req=4'b0001, din0=8'hA5, HOLD_CYCLES=8: ld high for 1 cycle with D_out=A5, gnt=0001 for 9 cycles, done[0] pulses once, owner=0.
- req=4'b1111 held: grants in order 0,1,2,3,0, each separated by 10 cycles, each D_out matching its din.
- clr_cmd and set_cmd together in IDLE: Clrn_out low for exactly one cycle, Setn_out stays 1, and a subsequent set_cmd alone gives Setn_out low for one cycle.
- set_cmd asserted during HOLD and held: ignored until IDLE, then Setn_out low for one cycle before any pending req is granted.
- Clrn pulsed low during HOLD of requester 2: gnt=0, done=0, busy=0, pointer=3. The next req=4'b0101 grants requester 0.
- Without LATCH8_SHARE_HOLD_EN: req=4'b0011 gives grants 0 and 1 two cycles apart, each gnt one cycle wide.
